// File: rtl/seq_adder_pkg.sv
// -----------------------------------------------------------------------------
// seq_adder_pkg
// Shared definitions for the sequential chunked adder:
//   - FSM state encoding (IDLE=0, RUN=1, DONE=2, 2 bits)
//   - parameter legality check for WIDTH/CHUNK
//   - chunk counter width helper ($clog2(N), never less than 1 bit)
// -----------------------------------------------------------------------------
package seq_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // WIDTH must be a positive whole multiple of CHUNK.
   function automatic bit params_ok(input int width, input int chunk);
      return (chunk > 0) && (chunk <= width) && ((width % chunk) == 0);
   endfunction

   // Counter width for N chunks; a single-chunk adder still gets one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage : seq_adder_pkg

// File: rtl/seq_adder_add_chunk.sv
// -----------------------------------------------------------------------------
// add_chunk
// Purely combinational CHUNK-bit adder slice.
// Ports:
//   x, y   [CHUNK-1:0] : chunk operands
//   ci                 : carry into bit 0 of the chunk
//   sum    [CHUNK-1:0] : chunk sum
//   co                 : carry out of the top bit of the chunk
//   c_msb              : carry into the top bit of the chunk (for overflow)
// -----------------------------------------------------------------------------
module add_chunk #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] x,
   input  logic [CHUNK-1:0] y,
   input  logic             ci,
   output logic [CHUNK-1:0] sum,
   output logic             co,
   output logic             c_msb
);

   logic [CHUNK:0] full_s;

   // Chunk addition with one extra bit to catch the carry out.
   always_comb begin
      full_s = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
      sum    = full_s[CHUNK-1:0];
      co     = full_s[CHUNK];
      // sum bit = x ^ y ^ carry_in, so the carry into the top bit is recovered
      // without slicing below the MSB (keeps CHUNK=1 legal).
      c_msb  = full_s[CHUNK-1] ^ x[CHUNK-1] ^ y[CHUNK-1];
   end

endmodule : add_chunk

// File: rtl/seq_adder.sv
// -----------------------------------------------------------------------------
// seq_adder
// Sequential adder/subtractor that processes CHUNK bits per clock.
// An accepted operation takes N = WIDTH/CHUNK cycles in RUN, then one DONE
// cycle with a done pulse. Results are held in a dedicated result register.
// Ports:
//   clk            : clock, rising edge
//   rst            : synchronous active-high reset (priority over start)
//   start          : request; accepted in IDLE or DONE, ignored in RUN
//   a, b [WIDTH]   : operands
//   c_in           : carry-in (add only)
//   sub            : 0 -> a+b+c_in, 1 -> a-b
//   busy           : high while in RUN
//   done           : one-cycle completion pulse
//   s [WIDTH]      : sum / difference
//   c_out          : carry out of MSB (for subtract: 1 = no borrow)
//   ovf            : two's-complement overflow
// -----------------------------------------------------------------------------
module seq_adder
   import seq_adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             c_out,
   output logic             ovf
);

   localparam int N  = WIDTH / CHUNK;
   localparam int CW = cnt_width(N);
   localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

   generate
      if (!params_ok(WIDTH, CHUNK)) begin : g_bad_params
         $error("seq_adder: WIDTH must be a positive multiple of CHUNK");
      end
   endgenerate

   state_e           state_r;
   state_e           next_state_s;
   logic             accept_s;
   logic             last_s;
   logic             busy_d_s;
   logic             done_d_s;
   logic             busy_r;
   logic             done_r;

   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic             carry_r;
   logic [CW-1:0]    cnt_r;
   logic [WIDTH-1:0] work_r;

   logic [WIDTH-1:0] s_r;
   logic             c_out_r;
   logic             ovf_r;

   int               idx_s;
   logic [CHUNK-1:0] chunk_x_s;
   logic [CHUNK-1:0] chunk_y_s;
   logic [CHUNK-1:0] chunk_sum_s;
   logic             chunk_co_s;
   logic             chunk_msb_s;
   logic [WIDTH-1:0] full_sum_s;

   // Select the current chunk of the captured operands.
   always_comb begin
      idx_s     = int'(cnt_r) * CHUNK;
      chunk_x_s = a_r[idx_s +: CHUNK];
      chunk_y_s = b_r[idx_s +: CHUNK];
      last_s    = (cnt_r == LAST_CNT);
   end

   add_chunk #(
      .CHUNK (CHUNK)
   ) u_add_chunk (
      .x     (chunk_x_s),
      .y     (chunk_y_s),
      .ci    (carry_r),
      .sum   (chunk_sum_s),
      .co    (chunk_co_s),
      .c_msb (chunk_msb_s)
   );

   // Working sum with the current chunk merged in (complete on the last chunk).
   always_comb begin
      full_sum_s                     = work_r;
      full_sum_s[idx_s +: CHUNK]     = chunk_sum_s;
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // FSM next-state logic and start acceptance.
   always_comb begin
      next_state_s = state_r;
      accept_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               accept_s     = 1'b1;
               next_state_s = RUN;
            end else begin
               next_state_s = IDLE;
            end
         end
         RUN: begin
            if (last_s) begin
               next_state_s = DONE;
            end else begin
               next_state_s = RUN;
            end
         end
         DONE: begin
            if (start) begin
               accept_s     = 1'b1;
               next_state_s = RUN;
            end else begin
               next_state_s = IDLE;
            end
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

   // FSM output decode, registered below so busy/done come straight from flops.
   always_comb begin
      busy_d_s = (next_state_s == RUN);
      done_d_s = (state_r == RUN) && last_s;
   end

   // Registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         busy_r <= busy_d_s;
         done_r <= done_d_s;
      end
   end

   // Operand capture and per-chunk datapath stepping.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_r     <= {WIDTH{1'b0}};
         b_r     <= {WIDTH{1'b0}};
         carry_r <= 1'b0;
         cnt_r   <= {CW{1'b0}};
         work_r  <= {WIDTH{1'b0}};
      end else if (accept_s) begin
         // Subtraction is a + ~b + 1.
         a_r     <= a;
         b_r     <= sub ? ~b : b;
         carry_r <= sub ? 1'b1 : c_in;
         cnt_r   <= {CW{1'b0}};
         work_r  <= {WIDTH{1'b0}};
      end else if (state_r == RUN) begin
         carry_r <= chunk_co_s;
         work_r  <= full_sum_s;
         // Counter parks on the last chunk instead of wrapping.
         if (!last_s) begin
            cnt_r <= cnt_r + CW'(1);
         end else begin
            cnt_r <= cnt_r;
         end
      end else begin
         carry_r <= carry_r;
         cnt_r   <= cnt_r;
      end
   end

   // Result register: written only on the completion edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_r     <= {WIDTH{1'b0}};
         c_out_r <= 1'b0;
         ovf_r   <= 1'b0;
      end else if ((state_r == RUN) && last_s) begin
         s_r     <= full_sum_s;
         c_out_r <= chunk_co_s;
         ovf_r   <= chunk_co_s ^ chunk_msb_s;
      end else begin
         s_r     <= s_r;
         c_out_r <= c_out_r;
         ovf_r   <= ovf_r;
      end
   end

   assign busy  = busy_r;
   assign done  = done_r;
   assign s     = s_r;
   assign c_out = c_out_r;
   assign ovf   = ovf_r;

endmodule : seq_adder

// File: tb/tb_seq_adder.sv
// -----------------------------------------------------------------------------
// tb_seq_adder
// Self-checking bench: a 16-bit/4-bit-chunk instance and an 8-bit single-chunk
// instance, checked against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_seq_adder;

   localparam int N16 = 4;

   logic        clk = 1'b0;
   logic        rst;

   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        c_in;
   logic        sub;
   logic        busy;
   logic        done;
   logic [15:0] s;
   logic        c_out;
   logic        ovf;

   logic        start8;
   logic [7:0]  a8;
   logic [7:0]  b8;
   logic        c_in8;
   logic        sub8;
   logic        busy8;
   logic        done8;
   logic [7:0]  s8;
   logic        c_out8;
   logic        ovf8;

   int          n_vec = 0;
   int          n_err = 0;
   logic [17:0] prev_res;   // {ovf, c_out, s} expected to be held

   always #5 clk = ~clk;

   seq_adder #(.WIDTH(16), .CHUNK(4)) u_dut16 (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c_in(c_in), .sub(sub),
      .busy(busy), .done(done), .s(s), .c_out(c_out), .ovf(ovf)
   );

   seq_adder #(.WIDTH(8), .CHUNK(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .c_in(c_in8), .sub(sub8),
      .busy(busy8), .done(done8), .s(s8), .c_out(c_out8), .ovf(ovf8)
   );

   // Reference: full-precision arithmetic, overflow from operand/result signs.
   function automatic logic [17:0] model16(input logic [15:0] ma, mb, input logic mc, ms);
      logic [15:0] bb;
      logic [16:0] full;
      logic        v;
      bb   = ms ? ~mb : mb;
      full = 17'(ma) + 17'(bb) + 17'(ms ? 1'b1 : mc);
      v    = (ma[15] == bb[15]) && (full[15] != ma[15]);
      return {v, full[16], full[15:0]};
   endfunction

   function automatic logic [9:0] model8(input logic [7:0] ma, mb, input logic mc, ms);
      logic [7:0] bb;
      logic [8:0] full;
      logic       v;
      bb   = ms ? ~mb : mb;
      full = 9'(ma) + 9'(bb) + 9'(ms ? 1'b1 : mc);
      v    = (ma[7] == bb[7]) && (full[7] != ma[7]);
      return {v, full[8], full[7:0]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One operation on the 16-bit DUT with start pulsed for a single cycle.
   task automatic do_op(input string tag, input logic [15:0] ta, tb,
                        input logic tcin, tsub, input logic [17:0] expv);
      int cyc;
      int busy_cnt;
      bit seen;
      @(negedge clk);
      a = ta; b = tb; c_in = tcin; sub = tsub; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      // Scramble inputs after capture; they must not affect the result.
      a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom); sub = 1'($urandom);
      cyc = 1; busy_cnt = 0; seen = 1'b0;
      while (!seen && cyc <= 3 * N16) begin
         if (done === 1'b1) begin
            seen = 1'b1;
         end else begin
            if (busy === 1'b1) busy_cnt++;
            chk({tag, "_hold_s"}, 32'(s), 32'(prev_res[15:0]));
            @(negedge clk);
            cyc++;
         end
      end
      chk({tag, "_latency"}, 32'(cyc), 32'(N16 + 1));
      chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(N16));
      chk({tag, "_s"}, 32'(s), 32'(expv[15:0]));
      chk({tag, "_c_out"}, 32'(c_out), 32'(expv[16]));
      chk({tag, "_ovf"}, 32'(ovf), 32'(expv[17]));
      chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      prev_res = expv;
      @(negedge clk);
      chk({tag, "_done_pulse"}, 32'(done), 32'd0);
   endtask

   initial begin
      logic [15:0] ra, rb;
      logic        rc, rs;
      logic [15:0] qa [0:4];
      logic [15:0] qb [0:4];
      logic        qc [0:4];
      logic        qs [0:4];
      logic [9:0]  e8;

      rst = 1'b1; start = 1'b0; a = 16'h0; b = 16'h0; c_in = 1'b0; sub = 1'b0;
      start8 = 1'b0; a8 = 8'h0; b8 = 8'h0; c_in8 = 1'b0; sub8 = 1'b0;
      prev_res = 18'h0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_s", 32'(s), 32'd0);
      chk("rst_flags", 32'({c_out, ovf}), 32'd0);
      chk("rst_busy8", 32'(busy8), 32'd0);
      chk("rst_s8", 32'(s8), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Directed cases
      do_op("ffff_p1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h0000});
      do_op("7fff_p1", 16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h8000});
      do_op("1234_4321_ci", 16'h1234, 16'h4321, 1'b1, 1'b0, {1'b0, 1'b0, 16'h5556});
      do_op("sub_5_7", 16'h0005, 16'h0007, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFE});
      do_op("sub_8000_1", 16'h8000, 16'h0001, 1'b1, 1'b1, {1'b1, 1'b1, 16'h7FFF});

      // Random operations against the model
      for (int i = 0; i < 20; i++) begin
         ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
         do_op("rand", ra, rb, rc, rs, model16(ra, rb, rc, rs));
      end

      // start held high: back-to-back ops, done every N+1 cycles
      for (int j = 0; j < 5; j++) begin
         qa[j] = 16'($urandom); qb[j] = 16'($urandom);
         qc[j] = 1'($urandom);  qs[j] = 1'($urandom);
      end
      @(negedge clk);
      a = qa[0]; b = qb[0]; c_in = qc[0]; sub = qs[0]; start = 1'b1;
      @(negedge clk);
      for (int j = 0; j < 4; j++) begin
         for (int c = 1; c <= N16; c++) begin
            chk("b2b_busy", 32'(busy), 32'd1);
            chk("b2b_nodone", 32'(done), 32'd0);
            chk("b2b_hold_s", 32'(s), 32'(prev_res[15:0]));
            if (c == 1) begin
               a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom); sub = 1'($urandom);
            end else if (c == N16) begin
               a = qa[j+1]; b = qb[j+1]; c_in = qc[j+1]; sub = qs[j+1];
            end
            @(negedge clk);
         end
         prev_res = model16(qa[j], qb[j], qc[j], qs[j]);
         chk("b2b_done", 32'(done), 32'd1);
         chk("b2b_busy_done", 32'(busy), 32'd0);
         chk("b2b_result", 32'({ovf, c_out, s}), 32'(prev_res));
         @(negedge clk);
      end
      start = 1'b0;
      repeat (N16 + 2) @(negedge clk);

      // Reset during RUN aborts
      a = 16'h1111; b = 16'h2222; c_in = 1'b0; sub = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_s", 32'(s), 32'd0);
      chk("abort_flags", 32'({c_out, ovf}), 32'd0);
      prev_res = 18'h0;
      for (int c = 0; c < 6; c++) begin
         chk("abort_nodone", 32'(done), 32'd0);
         @(negedge clk);
      end
      do_op("after_abort", 16'hABCD, 16'h1357, 1'b1, 1'b0, model16(16'hABCD, 16'h1357, 1'b1, 1'b0));

      // Single-chunk instance: done one edge after acceptance
      for (int i = 0; i < 6; i++) begin
         if (i == 0) begin
            a8 = 8'hC8; b8 = 8'h64; c_in8 = 1'b0; sub8 = 1'b0;
         end else begin
            a8 = 8'($urandom); b8 = 8'($urandom); c_in8 = 1'($urandom); sub8 = 1'($urandom);
         end
         e8 = model8(a8, b8, c_in8, sub8);
         if (i == 0) chk("n1_model_c8_64", 32'(e8), 32'({1'b0, 1'b1, 8'h2C}));
         start8 = 1'b1;
         @(negedge clk);
         start8 = 1'b0;
         a8 = 8'($urandom); b8 = 8'($urandom);
         chk("n1_busy", 32'(busy8), 32'd1);
         chk("n1_nodone", 32'(done8), 32'd0);
         @(negedge clk);
         chk("n1_done", 32'(done8), 32'd1);
         chk("n1_busy_done", 32'(busy8), 32'd0);
         chk("n1_result", 32'({ovf8, c_out8, s8}), 32'(e8));
         @(negedge clk);
         chk("n1_done_pulse", 32'(done8), 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_seq_adder
